// File: rtl/isa_pkg.sv
// Shared ISA definitions: alu_op codes, instruction-word field layout,
// and the state type of the program loader.
package isa_pkg;

    // alu_op codes that the encoder treats specially
    localparam logic [4:0] OP_NOP   = 5'b00000;
    localparam logic [4:0] OP_ILL_A = 5'b10001;
    localparam logic [4:0] OP_ILL_B = 5'b10010;
    localparam logic [4:0] OP_ILL_C = 5'b10111;
    localparam logic [4:0] OP_JE    = 5'b11000;
    localparam logic [4:0] OP_LI    = 5'b11110;
    localparam logic [4:0] OP_SHOWR = 5'b11111;

    // Format select bit: 0 = register/register, 1 = register/immediate
    localparam int FMT_BIT  = 15;

    // Format 1 fields
    localparam int FUNC_HI  = 14;
    localparam int FUNC_LO  = 6;
    localparam int F1_A_HI  = 5;
    localparam int F1_A_LO  = 3;
    localparam int F1_B_HI  = 2;
    localparam int F1_B_LO  = 0;

    // Format 2 fields
    localparam int F2_C_HI  = 14;
    localparam int F2_C_LO  = 11;
    localparam int F2_A_HI  = 10;
    localparam int F2_A_LO  = 8;
    localparam int F2_IM_HI = 7;
    localparam int F2_IM_LO = 0;

    // ShowR is not a plain ALU op; it borrows this func code
    localparam logic [8:0] FUNC_SHOWR = 9'd18;
    // Format 2 condition field is the op minus this base
    localparam logic [4:0] COND_BASE  = 5'd24;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_CHECK
    } asm_state_e;

    // Op codes that have no encoding in either format
    function automatic logic is_illegal(input logic [4:0] op);
        return (op == OP_ILL_A) || (op == OP_ILL_B) || (op == OP_ILL_C);
    endfunction

endpackage

// File: rtl/instr_encode.sv
// Combinational mnemonic -> 16-bit instruction word encoder.
// Also used stand-alone as a golden model by the decoder bench.
module instr_encode (
    input  logic [4:0]  op_i,
    input  logic [2:0]  a_i,
    input  logic [2:0]  b_i,
    input  logic [7:0]  im8_i,
    output logic [15:0] word_o,
    output logic        illegal_o
);
    import isa_pkg::*;

    logic [3:0] cond;

    // Only meaningful for ops JE..LI, where the difference fits in 4 bits
    assign cond = 4'(op_i - COND_BASE);

    // Pick the format from the op and pack the fields; illegal ops and NOP give zero
    always_comb begin
        word_o    = '0;
        illegal_o = is_illegal(op_i);
        if (illegal_o || (op_i == OP_NOP)) begin
            word_o = '0;
        end else if (op_i == OP_SHOWR) begin
            word_o[FMT_BIT]           = 1'b0;
            word_o[FUNC_HI:FUNC_LO]   = FUNC_SHOWR;
            word_o[F1_A_HI:F1_A_LO]   = a_i;
            word_o[F1_B_HI:F1_B_LO]   = b_i;
        end else if ((op_i >= OP_JE) && (op_i <= OP_LI)) begin
            word_o[FMT_BIT]           = 1'b1;
            word_o[F2_C_HI:F2_C_LO]   = cond;
            word_o[F2_A_HI:F2_A_LO]   = a_i;
            word_o[F2_IM_HI:F2_IM_LO] = im8_i;
        end else begin
            word_o[FMT_BIT]           = 1'b0;
            word_o[FUNC_HI:FUNC_LO]   = {4'b0000, op_i};
            word_o[F1_A_HI:F1_A_LO]   = a_i;
            word_o[F1_B_HI:F1_B_LO]   = b_i;
        end
    end

endmodule

// File: rtl/instr_assembler.sv
// Program loader: encodes each accepted command, writes it to instruction
// memory at an auto-incrementing address, reads it back and verifies it.
module instr_assembler #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_op,
    input  logic [2:0]        in_a,
    input  logic [2:0]        in_b,
    input  logic [7:0]        in_im8,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              busy,
    output logic              err_illegal,
    output logic              err_verify
);
    import isa_pkg::*;

    localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};

    asm_state_e        state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [15:0]       mem_wdata_q, mem_wdata_d;
    logic              err_ill_q, err_ill_d;
    logic              err_ver_q, err_ver_d;

    logic [15:0]       enc_word;
    logic              enc_illegal;

    instr_encode u_encode (
        .op_i      (in_op),
        .a_i       (in_a),
        .b_i       (in_b),
        .im8_i     (in_im8),
        .word_o    (enc_word),
        .illegal_o (enc_illegal)
    );

    assign full        = (count_q == DEPTH_CNT);
    assign in_ready    = (state_q == S_IDLE) && !full && !clear;
    assign busy        = (state_q != S_IDLE);
    assign count       = count_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign err_illegal = err_ill_q;
    assign err_verify  = err_ver_q;

    // Next-state: write/read/check sequence per command; clear overrides everything.
    // mem_wdata_q doubles as the latched word for the readback compare.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        err_ill_d   = err_ill_q;
        err_ver_d   = err_ver_q;
        if (clear) begin
            state_d   = S_IDLE;
            wr_ptr_d  = '0;
            count_d   = '0;
            err_ill_d = 1'b0;
            err_ver_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        if (enc_illegal) begin
                            err_ill_d = 1'b1;
                        end else begin
                            state_d     = S_WRITE;
                            mem_we_d    = 1'b1;
                            mem_addr_d  = wr_ptr_q;
                            mem_wdata_d = enc_word;
                        end
                    end
                end
                S_WRITE: state_d = S_READ;
                S_READ:  state_d = S_CHECK;
                S_CHECK: begin
                    if (mem_rdata != mem_wdata_q) begin
                        err_ver_d = 1'b1;
                    end
                    wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                    count_d  = count_q + (ADDR_W + 1)'(1);
                    state_d  = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and output registers; reset also zeroes the memory bus
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            err_ill_q   <= 1'b0;
            err_ver_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            err_ill_q   <= err_ill_d;
            err_ver_q   <= err_ver_d;
        end
    end

endmodule
